// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write arbiter and the register file.
// Defaults here must stay in step with the register file's own WIDTH/ADDR_WIDTH.
package regfile_write_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

  // Ceiling log2 for n >= 2; used to size requester indices.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_picker.sv
// Round-robin priority picker: finds the first set mask bit at or after i_start,
// wrapping modulo N. Purely combinational.
module rr_priority_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_mask,
  input  logic [IDX_W-1:0] i_start,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N);

  // One extra bit holds start+k before the modulo-N fold (max 2N-2).
  always_comb begin
    logic [IDX_W:0] w_sum;
    w_sum   = '0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = {1'b0, i_start} + (IDX_W+1)'(k);
      if (w_sum >= N_L) w_sum = w_sum - N_L;
      if (!o_found && i_mask[w_sum[IDX_W-1:0]]) begin
        o_found = 1'b1;
        o_idx   = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the two register-file write ports among N_REQ requesters: up to two
// round-robin grants per cycle, never two to the same address, registered outputs.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter  int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  localparam int unsigned IDX_W      = clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        hold,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*WIDTH-1:0]      req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rf_ce,
  output logic                        rf_en,
  output logic [1:0]                  rf_we,
  output logic [ADDR_WIDTH-1:0]       rf_waddress1,
  output logic [WIDTH-1:0]            rf_wdata1,
  output logic [ADDR_WIDTH-1:0]       rf_waddress2,
  output logic [WIDTH-1:0]            rf_wdata2,
  output logic [IDX_W-1:0]            rr_ptr
);

  logic [ADDR_WIDTH-1:0] w_addr [N_REQ];
  logic [WIDTH-1:0]      w_data [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_addr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data[g] = req_data[g*WIDTH +: WIDTH];
  end

  logic [N_REQ-1:0]      w_mask1;
  logic [N_REQ-1:0]      w_mask2;
  logic                  w_found1;
  logic                  w_found2;
  logic [IDX_W-1:0]      w_pick1;
  logic [IDX_W-1:0]      w_pick2;
  logic [IDX_W-1:0]      w_start2;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic                  w_grant1;
  logic                  w_grant2;

  logic [IDX_W-1:0]      r_ptr;
  logic [1:0]            r_we;
  logic                  r_en;
  logic                  r_ce;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic [WIDTH-1:0]      r_data1;
  logic [ADDR_WIDTH-1:0] r_addr2;
  logic [WIDTH-1:0]      r_data2;

  assign w_mask1 = (reset_n && !hold) ? req_valid : '0;

  rr_priority_picker #(.N(N_REQ), .IDX_W(IDX_W)) u_pick1 (
    .i_mask  (w_mask1),
    .i_start (r_ptr),
    .o_found (w_found1),
    .o_idx   (w_pick1)
  );

  // The second scan must stop before rr_ptr, but every valid requester between
  // rr_ptr and pick1 was already rejected by pick 1, so a full wrap is equivalent.
  always_comb begin
    w_mask2 = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      w_mask2[i] = w_mask1[i] && (IDX_W'(i) != w_pick1) && (w_addr[i] != w_addr[w_pick1]);
  end

  assign w_start2 = IDX_W'(wrap_inc(32'(w_pick1), N_REQ));

  rr_priority_picker #(.N(N_REQ), .IDX_W(IDX_W)) u_pick2 (
    .i_mask  (w_mask2),
    .i_start (w_start2),
    .o_found (w_found2),
    .o_idx   (w_pick2)
  );

  assign w_grant1 = w_found1;
  assign w_grant2 = w_found1 && w_found2;

  always_comb begin
    req_ready = '0;
    if (w_grant1) req_ready[w_pick1] = 1'b1;
    if (w_grant2) req_ready[w_pick2] = 1'b1;
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_grant2)      w_ptr_nxt = IDX_W'(wrap_inc(32'(w_pick2), N_REQ));
    else if (w_grant1) w_ptr_nxt = w_start2;
  end

  // Port 2 is only ever used alongside port 1, so |rf_we reduces to grant 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_we    <= '0;
      r_en    <= 1'b0;
      r_ce    <= 1'b0;
      r_addr1 <= '0;
      r_data1 <= '0;
      r_addr2 <= '0;
      r_data2 <= '0;
    end else begin
      r_ce  <= 1'b1;
      r_ptr <= w_ptr_nxt;
      r_we  <= {w_grant2, w_grant1};
      r_en  <= w_grant1;
      if (w_grant1) begin
        r_addr1 <= w_addr[w_pick1];
        r_data1 <= w_data[w_pick1];
      end
      if (w_grant2) begin
        r_addr2 <= w_addr[w_pick2];
        r_data2 <= w_data[w_pick2];
      end
    end
  end

  assign rr_ptr       = r_ptr;
  assign rf_we        = r_we;
  assign rf_en        = r_en;
  assign rf_ce        = r_ce;
  assign rf_waddress1 = r_addr1;
  assign rf_wdata1    = r_data1;
  assign rf_waddress2 = r_addr2;
  assign rf_wdata2    = r_data2;

endmodule
